// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction prefetch pipeline.
//   PIPE_ADDR_WIDTH : default instruction address width
//   PIPE_DATA_WIDTH : default instruction word width
//   pipe_state_e    : fetch controller states (IDLE, FETCH, HALT)
package pipe_pkg;

    localparam int PIPE_ADDR_WIDTH = 8;
    localparam int PIPE_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/im_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and decode.
//   im_addr_o / im_rd_o : read request to instruction memory
//   im_r_data_i         : read data, valid exactly one cycle after im_rd_o
//   inst_o / pc_o       : head instruction and its address
//   inst_valid_o        : head entry valid
//   inst_ready_i        : consumer accepts head
// Modports: master = prefetch queue, slave = memory/decode side.
//
// Handshake: the head transfers on a cycle where inst_valid_o and
// inst_ready_i are both high. While inst_valid_o is high and
// inst_ready_i is low, inst_o and pc_o hold their value. inst_valid_o
// does not depend on inst_ready_i.
interface im_prefetch_queue_if
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = PIPE_ADDR_WIDTH,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] im_addr_o;
    logic                  im_rd_o;
    logic [DATA_WIDTH-1:0] im_r_data_i;
    logic [DATA_WIDTH-1:0] inst_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  inst_valid_o;
    logic                  inst_ready_i;

    modport master (
        output im_addr_o, im_rd_o, inst_o, pc_o, inst_valid_o,
        input  im_r_data_i, inst_ready_i
    );

    modport slave (
        input  im_addr_o, im_rd_o, inst_o, pc_o, inst_valid_o,
        output im_r_data_i, inst_ready_i
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO storage for the prefetch queue.
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : empties the FIFO; wins over push and pop
//   push/data  : write one entry
//   pop        : drop the head entry (ignored when empty)
//   head       : entry at the read pointer
//   count      : occupied entries
//   empty      : count is zero
// Storage is cleared on reset so the head reads as zero while in reset.
module sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/im_prefetch_queue.sv
// Instruction prefetch queue: issues sequential instruction memory reads
// and buffers the returned words with their addresses for decode.
//   clk, rst        : clock, asynchronous active-low reset
//   start / stop    : begin/resume fetching; level that halts new fetches
//   redirect_i      : flush queue and restart from redirect_addr_i
//   count_o         : occupied queue entries
//   fsm_state       : current fetch controller state (debug)
//   bus             : memory request/response and head instruction stream
// Optional build macro PREFETCH_BYPASS_EN: a word arriving while the queue
// is empty is presented on the head in its arrival cycle.
module im_prefetch_queue
    import pipe_pkg::*;
#(
    parameter  int ADDR_WIDTH = PIPE_ADDR_WIDTH,
    parameter  int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic [CW-1:0]         count_o,
    output pipe_state_e           fsm_state,
    im_prefetch_queue_if.master   bus
);

    pipe_state_e           state;
    pipe_state_e           state_nxt;
    logic                  issue;
    logic                  inflight;
    logic                  resp_valid;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [CW:0]           occupancy;
    logic                  credit;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;

    // Credit counts the read in flight, so its response always has a slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign credit    = occupancy < (CW + 1)'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop dominates start. No read is issued in a redirect cycle, so the
    // first read after a redirect uses the new address next cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) state_nxt = FETCH;
            end
            FETCH: begin
                issue = credit && !redirect_i;
                if (stop) state_nxt = HALT;
            end
            HALT: begin
                if (start && !stop) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr <= '0;
            resp_addr  <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight  <= issue;
            resp_addr <= fetch_addr;
            if (redirect_i) begin
                fetch_addr <= redirect_addr_i;
            end else if (issue) begin
                fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // A response coinciding with a redirect belongs to the old stream.
    assign resp_valid = inflight && !redirect_i;
    assign fifo_pop   = bus.inst_ready_i && !fifo_empty;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass           = fifo_empty && resp_valid;
    assign fifo_push        = resp_valid && !(bypass && bus.inst_ready_i);
    assign bus.inst_valid_o = !fifo_empty || resp_valid;
    assign bus.inst_o       = bypass ? bus.im_r_data_i : head[ADDR_WIDTH +: DATA_WIDTH];
    assign bus.pc_o         = bypass ? resp_addr : head[ADDR_WIDTH-1:0];
`else
    assign fifo_push        = resp_valid;
    assign bus.inst_valid_o = !fifo_empty;
    assign bus.inst_o       = head[ADDR_WIDTH +: DATA_WIDTH];
    assign bus.pc_o         = head[ADDR_WIDTH-1:0];
`endif

    sync_fifo #(
        .WIDTH (DATA_WIDTH + ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (fifo_push),
        .push_data ({bus.im_r_data_i, resp_addr}),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.im_rd_o   = issue;
    assign bus.im_addr_o = fetch_addr;
    assign count_o       = fifo_count;
    assign fsm_state     = state;

endmodule
